// File: rtl/dot_mac_pipe.sv
// Pipelined N-tap signed dot-product MAC: product leaves, registered adder tree, accumulator stage.
// Optional macro DOT_MAC_SAT_EN: saturate the scaled output and add sat_flag_out.
module dot_mac_pipe #(
    parameter int unsigned A_WIDTH           = 16,
    parameter int unsigned B_WIDTH           = 16,
    parameter int unsigned N_TAPS            = 9,
    parameter int unsigned ACCUMULATOR_WIDTH = 32,
    parameter int unsigned OUTPUT_WIDTH      = 16,
    parameter int unsigned OUTPUT_SCALE      = 0
) (
    input  logic                                clk,
    input  logic                                arst_n_in,
    input  logic                                input_valid,
    input  logic                                stall_in,
    input  logic                                accumulate_internal,
    input  logic                                psum_en,
    input  logic signed [ACCUMULATOR_WIDTH-1:0] partial_sum_in,
    input  logic        [N_TAPS*A_WIDTH-1:0]    a_in,
    input  logic        [N_TAPS*B_WIDTH-1:0]    b_in,
    output logic        [OUTPUT_WIDTH-1:0]      out,
    output logic                                out_valid
`ifdef DOT_MAC_SAT_EN
    ,
    output logic                                sat_flag_out
`endif
);

    localparam int unsigned NumLeaves = N_TAPS + 1;
    localparam int unsigned TreeDepth = $clog2(NumLeaves);
    localparam int unsigned NumPad    = 1 << TreeDepth;
    localparam int unsigned NumNodes  = 2 * NumPad - 1;
    localparam int unsigned LeafBase  = NumPad - 1;
    localparam int unsigned ProdWidth = A_WIDTH + B_WIDTH;

    typedef logic signed [ACCUMULATOR_WIDTH-1:0] acc_t;

    logic signed [ProdWidth-1:0] a_ext [N_TAPS];
    logic signed [ProdWidth-1:0] b_ext [N_TAPS];
    logic signed [ProdWidth-1:0] prod  [N_TAPS];

    // Heap-ordered tree: node i has children 2i+1 and 2i+2, root at 0, leaves from LeafBase.
    // Every node is registered, so each tree level is one pipeline stage.
    acc_t tree_d [NumNodes];
    acc_t tree_q [NumNodes];

    logic [TreeDepth:0]    valid_q;
    logic [TreeDepth:0]    flag_q;
    acc_t                  acc_d;
    acc_t                  acc_q;
    logic [OUTPUT_WIDTH-1:0] out_d;
    logic [OUTPUT_WIDTH-1:0] out_q;
    logic                  out_valid_q;

`ifdef DOT_MAC_SAT_EN
    localparam acc_t SatMax = acc_t'((64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1);
    localparam acc_t SatMin = ~SatMax;

    acc_t shifted;
    logic clipped;
    logic sat_q;
`endif

    always_comb begin
        for (int k = 0; k < int'(N_TAPS); k++) begin
            a_ext[k] = ProdWidth'($signed(a_in[k*A_WIDTH +: A_WIDTH]));
            b_ext[k] = ProdWidth'($signed(b_in[k*B_WIDTH +: B_WIDTH]));
            prod[k]  = a_ext[k] * b_ext[k];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NumNodes); i++) begin
            tree_d[i] = '0;
        end
        for (int i = 0; i < int'(LeafBase); i++) begin
            tree_d[i] = tree_q[2*i+1] + tree_q[2*i+2];
        end
        for (int k = 0; k < int'(N_TAPS); k++) begin
            tree_d[LeafBase+k] = acc_t'(prod[k]);
        end
        tree_d[LeafBase+N_TAPS] = psum_en ? partial_sum_in : '0;
    end

    always_comb begin
        acc_d = (flag_q[TreeDepth] ? acc_q : '0) + tree_q[0];
`ifdef DOT_MAC_SAT_EN
        shifted = acc_d >>> OUTPUT_SCALE;
        clipped = 1'b0;
        out_d   = shifted[OUTPUT_WIDTH-1:0];
        if (shifted > SatMax) begin
            out_d   = SatMax[OUTPUT_WIDTH-1:0];
            clipped = 1'b1;
        end else if (shifted < SatMin) begin
            out_d   = SatMin[OUTPUT_WIDTH-1:0];
            clipped = 1'b1;
        end
`else
        out_d = OUTPUT_WIDTH'(acc_d >>> OUTPUT_SCALE);
`endif
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            for (int i = 0; i < int'(NumNodes); i++) begin
                tree_q[i] <= '0;
            end
            valid_q     <= '0;
            flag_q      <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef DOT_MAC_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else if (!stall_in) begin
            tree_q      <= tree_d;
            valid_q     <= {valid_q[TreeDepth-1:0], input_valid};
            flag_q      <= {flag_q[TreeDepth-1:0], accumulate_internal};
            out_valid_q <= valid_q[TreeDepth];
`ifdef DOT_MAC_SAT_EN
            sat_q       <= 1'b0;
`endif
            // Bubbles leave acc and out untouched; only valid tokens update them.
            if (valid_q[TreeDepth]) begin
                acc_q <= acc_d;
                out_q <= out_d;
`ifdef DOT_MAC_SAT_EN
                sat_q <= clipped;
`endif
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
`ifdef DOT_MAC_SAT_EN
    assign sat_flag_out = sat_q;
`endif

endmodule
